// File: rtl/axi_lite_cmd_master.sv
// Command/response stream to AXI4-Lite master bridge: one outstanding transaction,
// with a per-phase watchdog that turns a hung slave into an error response.
module axi_lite_cmd_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_RSP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;
  logic              timeout_q, timeout_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              expire;
  logic              abort;
  logic              aw_hs, w_hs;

  // Counter sits at TIMEOUT-1 on the last permitted cycle of a phase.
  assign expire = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign aw_hs  = awvalid_q && m_axi_awready;
  assign w_hs   = wvalid_q && m_axi_wready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    timeout_d   = timeout_q;
    rsp_valid_d = rsp_valid_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    abort       = 1'b0;

    if (state_q inside {S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA}) begin
      cnt_d = (TIMEOUT != 0) ? cnt_q + 1'b1 : '0;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr & ~(ADDR_W'(3));
          wdata_d = cmd_wdata;
          cnt_d   = '0;
          if (cmd_write) begin
            state_d   = S_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        // A channel is finished once its valid has already dropped or handshakes now.
        if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
          state_d  = S_WR_RESP;
          bready_d = 1'b1;
          cnt_d    = '0;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (m_axi_bvalid && bready_q) begin
          state_d     = S_RSP;
          bready_d    = 1'b0;
          resp_d      = m_axi_bresp;
          rdata_d     = '0;
          timeout_d   = 1'b0;
          rsp_valid_d = 1'b1;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      S_RD_ADDR: begin
        if (arvalid_q && m_axi_arready) begin
          state_d   = S_RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          cnt_d     = '0;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      S_RD_DATA: begin
        if (m_axi_rvalid && rready_q) begin
          state_d     = S_RSP;
          rready_d    = 1'b0;
          rdata_d     = m_axi_rdata;
          resp_d      = m_axi_rresp;
          timeout_d   = 1'b0;
          rsp_valid_d = 1'b1;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog recovery deliberately drops valids mid-handshake.
    if (abort) begin
      state_d     = S_RSP;
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      rdata_d     = '0;
      resp_d      = 2'b10;
      timeout_d   = 1'b1;
      rsp_valid_d = 1'b1;
    end

    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
      timeout_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      timeout_q   <= timeout_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_timeout   = timeout_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: memory-backed AXI-Lite slave with programmable stalls,
// checked against a word-addressed reference memory and the phase timing rules.
module tb_axi_lite_cmd_master;
  localparam int TO = 8;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [7:0]  m_axi_awaddr, m_axi_araddr;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  axi_lite_cmd_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Slave configuration, written only by the stimulus process.
  int         cfg_aw_d, cfg_w_d, cfg_b_d, cfg_ar_d, cfg_r_d;
  bit         cfg_aw_never, cfg_ar_never;
  logic [1:0] cfg_bresp, cfg_rresp;
  int         cmd_seq = 0;

  logic [31:0] ref_mem   [0:63] = '{default: 32'h0};
  logic [31:0] slave_mem [0:63] = '{default: 32'h0};

  // Slave state, written only by the slave process.
  int          last_seq = 0;
  bit          aw_got, w_got, ar_got, b_arm, r_arm;
  bit          aw_hs_p, w_hs_p, b_hs_p, ar_hs_p, r_hs_p;
  int          aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;
  int          aw_hi, w_hi, ar_hi, aw_chg, n_b = 0;
  bit          prev_awv;
  logic [7:0]  prev_awaddr, aw_addr_c, ar_addr_c;
  logic [31:0] w_data_c;

  // Slave reacts on the falling edge so its outputs are settled well before each rising edge.
  always @(negedge clk) begin
    if (!rst_n || last_seq != cmd_seq) begin
      last_seq = cmd_seq;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0; m_axi_rvalid = 0;
      m_axi_bresp = 0; m_axi_rresp = 0; m_axi_rdata = 0;
      aw_got = 0; w_got = 0; ar_got = 0; b_arm = 0; r_arm = 0;
      aw_hs_p = 0; w_hs_p = 0; b_hs_p = 0; ar_hs_p = 0; r_hs_p = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; aw_hi = 0; w_hi = 0; ar_hi = 0; aw_chg = 0;
      prev_awv = 0; prev_awaddr = 0;
    end else begin
      if (aw_hs_p) begin aw_got = 1; m_axi_awready = 0; end
      if (w_hs_p)  begin w_got = 1;  m_axi_wready = 0; end
      if (b_hs_p)  begin m_axi_bvalid = 0; n_b++; end
      if (ar_hs_p) begin ar_got = 1; m_axi_arready = 0; end
      if (r_hs_p)  m_axi_rvalid = 0;
      if (aw_got && w_got) begin
        if (cfg_bresp == 2'b00) slave_mem[aw_addr_c[7:2]] = w_data_c;
        aw_got = 0; w_got = 0; b_arm = 1; b_wait = cfg_b_d;
      end
      if (b_arm) begin
        if (b_wait == 0) begin m_axi_bvalid = 1; m_axi_bresp = cfg_bresp; b_arm = 0; end
        else b_wait--;
      end
      if (ar_got) begin ar_got = 0; r_arm = 1; r_wait = cfg_r_d; end
      if (r_arm) begin
        if (r_wait == 0) begin
          m_axi_rvalid = 1; m_axi_rdata = slave_mem[ar_addr_c[7:2]]; m_axi_rresp = cfg_rresp; r_arm = 0;
        end else r_wait--;
      end
      if (m_axi_awvalid) begin
        aw_hi++;
        if (!cfg_aw_never && aw_cnt >= cfg_aw_d) m_axi_awready = 1; else aw_cnt++;
      end else begin m_axi_awready = 0; aw_cnt = 0; end
      if (m_axi_wvalid) begin
        w_hi++;
        if (w_cnt >= cfg_w_d) m_axi_wready = 1; else w_cnt++;
      end else begin m_axi_wready = 0; w_cnt = 0; end
      if (m_axi_arvalid) begin
        ar_hi++;
        if (!cfg_ar_never && ar_cnt >= cfg_ar_d) m_axi_arready = 1; else ar_cnt++;
      end else begin m_axi_arready = 0; ar_cnt = 0; end
      if (prev_awv && m_axi_awvalid && m_axi_awaddr != prev_awaddr) aw_chg++;
      aw_hs_p = m_axi_awvalid && m_axi_awready;
      w_hs_p  = m_axi_wvalid && m_axi_wready;
      ar_hs_p = m_axi_arvalid && m_axi_arready;
      b_hs_p  = m_axi_bvalid && m_axi_bready;
      r_hs_p  = m_axi_rvalid && m_axi_rready;
      if (aw_hs_p) aw_addr_c = m_axi_awaddr;
      if (w_hs_p)  w_data_c  = m_axi_wdata;
      if (ar_hs_p) ar_addr_c = m_axi_araddr;
      prev_awv    = m_axi_awvalid && !aw_hs_p;
      prev_awaddr = m_axi_awaddr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int aw, input int w, input int b, input int ar, input int r,
                         input logic [1:0] br, input logic [1:0] rr, input bit awn, input bit arn);
    cfg_aw_d = aw; cfg_w_d = w; cfg_b_d = b; cfg_ar_d = ar; cfg_r_d = r;
    cfg_bresp = br; cfg_rresp = rr; cfg_aw_never = awn; cfg_ar_never = arn;
  endtask

  // One command end to end; called and returning on a falling edge.
  task automatic do_cmd(input bit wr, input logic [7:0] a, input logic [31:0] d,
                        input int hold, input bit queue_next, input bit chk_acc);
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    bit          exp_to;
    int          exp_lat, lat, acc_wait, nb0, mx;
    logic [7:0]  a_al;
    a_al   = a & 8'hFC;
    exp_to = wr ? cfg_aw_never : cfg_ar_never;
    mx     = (cfg_aw_d > cfg_w_d) ? cfg_aw_d : cfg_w_d;
    if (exp_to) begin
      exp_resp = 2'b10; exp_rdata = 0; exp_lat = TO + 1;
    end else if (wr) begin
      exp_resp = cfg_bresp; exp_rdata = 0; exp_lat = 3 + mx + cfg_b_d;
      if (cfg_bresp == 2'b00) ref_mem[a[7:2]] = d;
    end else begin
      exp_resp = cfg_rresp; exp_rdata = ref_mem[a[7:2]]; exp_lat = 3 + cfg_ar_d + cfg_r_d;
    end

    cmd_seq++;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    acc_wait = 0;
    while (cmd_ready !== 1'b1 && acc_wait < 50) begin @(negedge clk); acc_wait++; end
    if (cmd_ready !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_wait: cmd_ready not seen within 50 cycles");
      cmd_valid = 0;
      return;
    end
    if (chk_acc) chk("queued_accept_wait", acc_wait, 0);
    nb0 = n_b;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) cmd_valid = 0;
    end while (rsp_valid !== 1'b1 && lat < 100);
    chk("rsp_latency", lat, exp_lat);
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_resp", rsp_resp, exp_resp);
      chk("rsp_timeout", rsp_timeout, exp_to);
      chk("cmd_ready_in_rsp", cmd_ready, 0);
      if (h < hold) begin
        if (queue_next) begin cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h08; end
        @(negedge clk);
      end
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("rsp_valid_after_consume", rsp_valid, 0);
    chk("cmd_ready_after_consume", cmd_ready, 1);
    if (wr) begin
      chk("aw_valid_cycles", aw_hi, exp_to ? TO : cfg_aw_d + 1);
      chk("w_valid_cycles", w_hi, cfg_w_d + 1);
      chk("awaddr_changes", aw_chg, 0);
      chk("b_count", n_b - nb0, exp_to ? 0 : 1);
      if (!exp_to) chk("awaddr_aligned", aw_addr_c, a_al);
      if (!exp_to) chk("wdata", w_data_c, d);
    end else begin
      chk("ar_valid_cycles", ar_hi, exp_to ? TO : cfg_ar_d + 1);
      if (!exp_to) chk("araddr_aligned", ar_addr_c, a_al);
    end
    $display("txn %s addr=%02h data=%08h -> resp=%0d rdata=%08h timeout=%0b lat=%0d",
             wr ? "WR" : "RD", a, d, rsp_resp, rsp_rdata, rsp_timeout, lat);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
    set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    #3 rst_n = 0;
    #1;
    chk("reset_outputs", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                          m_axi_rready, rsp_valid, rsp_timeout, cmd_ready}, 0);
    chk("reset_payload", {m_axi_awaddr, rsp_resp}, 0);
    chk("reset_rdata", rsp_rdata, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    chk("cmd_ready_at_release", cmd_ready, 0);
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);

    // Zero-wait write then read back.
    do_cmd(1, 8'h04, 32'hDEADBEEF, 0, 0, 0);
    do_cmd(0, 8'h04, 32'h0, 0, 0, 0);

    // AW stalled four cycles, W immediate.
    set_cfg(4, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    do_cmd(1, 8'h10, 32'hA5A5_0F0F, 0, 0, 0);

    // Response backpressure with a queued command behind it.
    set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    do_cmd(1, 8'h08, 32'h12345678, 0, 0, 0);
    do_cmd(0, 8'h08, 32'h0, 10, 1, 0);
    do_cmd(0, 8'h08, 32'h0, 0, 0, 1);

    // Read address phase times out; next command runs normally.
    set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1);
    do_cmd(0, 8'h20, 32'h0, 0, 0, 0);
    set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    do_cmd(1, 8'h20, 32'hCAFE_0001, 0, 0, 0);

    // Unaligned address and slave error pass-through.
    set_cfg(0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0);
    do_cmd(1, 8'h07, 32'h1111_2222, 0, 0, 0);

    // Reset asserted while waiting for read data.
    set_cfg(0, 0, 0, 0, 6, 2'b00, 2'b00, 0, 0);
    cmd_seq++;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h04;
    @(negedge clk);
    cmd_valid = 0;
    for (int i = 0; i < 20 && m_axi_rready !== 1'b1; i++) @(negedge clk);
    chk("rready_before_reset", m_axi_rready, 1);
    #2 rst_n = 0;
    #1;
    chk("async_reset_outputs", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                m_axi_rready, rsp_valid, cmd_ready}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_rsp_after_reset", rsp_valid, 0);
    end
    chk("cmd_ready_after_reset", cmd_ready, 1);
    set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    do_cmd(1, 8'h30, 32'h0BAD_F00D, 0, 0, 0);
    do_cmd(0, 8'h30, 32'h0, 0, 0, 0);

    // Randomised traffic.
    for (int n = 0; n < 40; n++) begin
      bit         wr, nev;
      logic [1:0] er;
      wr  = 1'($urandom_range(0, 1));
      nev = ($urandom_range(0, 9) == 0);
      er  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'b00;
      set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), er, er, wr && nev, !wr && nev);
      do_cmd(wr, 8'($urandom_range(0, 63)), $urandom, $urandom_range(0, 2), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
- Upstream AXI4-Lite master that drives the register bridge's slave port from a simple command/response stream. Typical sources are a debug UART, a JTAG shim or a sequencer.
- Converts one command (read or write, address, data) into a complete AXI4-Lite transaction, then returns the result on a response stream.
- Single outstanding transaction, with a per-phase timeout so a hung slave cannot lock up the command source.

Parameters:
- ADDR_W, 8, AXI/command address width in bits.
- DATA_W, 32, data width in bits (fixed 32-bit word access).
- TIMEOUT, 255, maximum cycles to wait in any AXI handshake phase; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
- rsp_resp  out  2  AXI BRESP/RRESP, or 2'b10 on timeout
- rsp_timeout  out  1  response was produced by a timeout
- m_axi_awaddr out ADDR_W; m_axi_awvalid out 1; m_axi_awready in 1
- m_axi_wdata out DATA_W; m_axi_wvalid out 1; m_axi_wready in 1
- m_axi_bresp in 2; m_axi_bvalid in 1; m_axi_bready out 1
- m_axi_araddr out ADDR_W; m_axi_arvalid out 1; m_axi_arready in 1
- m_axi_rdata in DATA_W; m_axi_rresp in 2; m_axi_rvalid in 1; m_axi_rready out 1

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - All m_axi_*valid, bready, rready, rsp_valid, rsp_timeout = 0; cmd_ready = 0 while in reset.
  - Address/data/rdata/resp registers = 0.
  - Any in-flight transaction is dropped with no response.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1.
  - On accept, register addr with low 2 bits forced to 0 (word aligned), register wdata, clear the timeout counter.
  - Go to WR if cmd_write, else RD_ADDR.
- WR:
  - awvalid and wvalid both assert the cycle after accept.
  - Each deasserts independently the cycle after its own handshake (valid && ready); AW and W may complete in either order or the same cycle.
  - When both are done, go to WR_RESP. bready is asserted in WR_RESP only.
- WR_RESP:
  - On bvalid && bready, capture bresp, set rdata=0, go to RSP.
- RD_ADDR:
  - arvalid=1; on arready go to RD_DATA.
- RD_DATA:
  - rready=1; on rvalid capture rdata and rresp, go to RSP.
- RSP:
  - rsp_valid=1 with rsp_* stable until rsp_ready; then return to IDLE.
  - cmd_ready=0 throughout RSP (backpressure holds off new commands).
- Valid signals and payloads never change while valid is high and ready is low, except on timeout.
- Timeout (TIMEOUT>0):
  - The counter increments every cycle in WR, WR_RESP, RD_ADDR and RD_DATA, and clears on each state entry.
  - When counter == TIMEOUT-1 with no completing handshake, the next cycle deasserts every m_axi valid/ready and enters RSP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
  - Timeout abort is a debug recovery and is permitted to violate the AXI valid-hold rule.
  - A handshake in the same cycle as expiry wins; no timeout is reported.
- Minimum latency against a zero-wait slave (ready tied high, response the next cycle): accept at cycle N, AW/W at N+1, B at N+2, rsp_valid at N+3. Reads follow the same timing.
- Slave errors (resp=2'b10 or 2'b11) are passed through unchanged with rsp_timeout=0.

Test Plan:
- Write 0xDEADBEEF to 0x04, then read 0x04, against axi_lite_reg_bridge -> write rsp_resp=00, rsp_rdata=0; read rsp_resp=00, rsp_rdata=0xDEADBEEF; each rsp_valid 3 cycles after accept.
- Slave holds awready low for 4 cycles while wready is immediate -> wvalid drops after 1 cycle; awvalid and awaddr stay stable for 5 cycles; exactly one B accepted; rsp_resp=00.
- rsp_ready held low for 10 cycles after a read of 0x08=0x12345678 -> rsp_valid, rsp_rdata and rsp_resp stable; cmd_ready=0 throughout; a queued command is accepted only the cycle after rsp_ready.
- TIMEOUT=8, slave never asserts arready -> arvalid drops after 8 cycles; rsp_valid with rsp_resp=10, rsp_timeout=1, rsp_rdata=0; next command accepted normally.
- Command addr 0x07 -> m_axi_awaddr=0x04; slave returns bresp=11 -> rsp_resp=11, rsp_timeout=0.
- rst_n pulsed low during RD_DATA -> all valids 0 immediately (async); no rsp_valid; after release, cmd_ready=1 and a new write completes.
